// File: rtl/spram_arbiter.sv
// rtl/spram_arbiter.sv - round-robin arbiter sharing one single-port SRAM between fetch and data ports
// Grant is combinational; a one-entry tracking register routes the 1-cycle-late response.
module spram_arbiter #(
  parameter logic [31:0] BASE = 32'h0000_0000,
  parameter int unsigned SIZE = 'h80,
  parameter int unsigned AW   = $clog2(SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic [31:0]   p0_addr,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [31:0]   p0_rdata,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [3:0]    p1_be,
  input  logic [31:0]   p1_addr,
  input  logic [31:0]   p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [31:0]   p1_rdata,
  output logic          p1_err,
  output logic          ram_ce,
  output logic [AW-1:0] ram_addr,
  output logic [3:0]    ram_we,
  output logic [31:0]   ram_d,
  input  logic [31:0]   ram_q
);

  localparam logic [31:0] WIN_BYTES = 32'(4 * SIZE);

  logic        r_last;
  logic        r_valid;
  logic        r_port;
  logic        r_err;
  logic        r_wr;

  logic        w_pick1;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_any;
  logic [31:0] w_addr;
  logic [31:0] w_off;
  logic        w_inwin;
  logic [31:0] w_rsp_data;

  // Port 1 wins alone, or on a conflict when port 0 was granted last.
  always_comb begin
    w_pick1 = p1_req && (!p0_req || !r_last);
    w_gnt1  = !rst && w_pick1;
    w_gnt0  = !rst && p0_req && !w_pick1;
    w_any   = w_gnt0 || w_gnt1;
    w_addr  = w_pick1 ? p1_addr : p0_addr;
    w_off   = w_addr - BASE;
    w_inwin = w_off < WIN_BYTES;
  end

  assign p0_gnt   = w_gnt0;
  assign p1_gnt   = w_gnt1;
  assign ram_ce   = w_any && w_inwin;
  assign ram_we   = (w_gnt1 && w_inwin && p1_we) ? p1_be : 4'b0000;
  assign ram_addr = w_off[AW+1:2];
  assign ram_d    = w_pick1 ? p1_wdata : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last  <= 1'b1;
      r_valid <= 1'b0;
      r_port  <= 1'b0;
      r_err   <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      r_valid <= w_any;
      if (w_any) begin
        r_last <= w_gnt1;
        r_port <= w_gnt1;
        r_err  <= !w_inwin;
        r_wr   <= w_gnt1 && p1_we;
      end
    end
  end

  // Writes and errors return zero data; only in-window reads pass ram_q through.
  assign w_rsp_data = (r_valid && !r_err && !r_wr) ? ram_q : 32'h0;

  assign p0_rvalid = r_valid && !r_port;
  assign p1_rvalid = r_valid && r_port;
  assign p0_err    = p0_rvalid && r_err;
  assign p1_err    = p1_rvalid && r_err;
  assign p0_rdata  = p0_rvalid ? w_rsp_data : 32'h0;
  assign p1_rdata  = p1_rvalid ? w_rsp_data : 32'h0;

endmodule
